mult_ctrl: RTL and testbench

Sequencing controller for the shift-add multiplier datapath (`mult_frame`: 8-bit left-shifting multiplicand register A, 4-bit right-shifting multiplier register B, 8-bit product register P with adder).
- Accepts a one-cycle `start` request and drives the datapath load, shift, add and clear strobes.
- Bounds the iteration count with an internal counter.
- Reports `busy` while a multiply is in progress and pulses `done` for one cycle when P holds the final product.

---
 rtl/mult_ctrl.sv | 117 +++++++++++
 tb/tb_mult_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
// Sequencing controller for the shift-add multiplier datapath (A shifts left, B shifts right, P accumulates).
// Optional macro MULT_CTRL_EARLY_EXIT_EN: finish as soon as the B register reaches zero.
module mult_ctrl #(
    parameter int B_WIDTH = 4
) (
    input  logic Clk,
    input  logic reset,
    input  logic start,
    input  logic b_lsb,
    input  logic b_zero,
    output logic a_enable,
    output logic a_L,
    output logic b_enable,
    output logic b_L,
    output logic p_L,
    output logic Psel,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(B_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t        state, next;
    logic [CW-1:0] cnt;
    logic          last_iter;

    assign last_iter = (cnt == CW'(B_WIDTH - 1));

`ifndef MULT_CTRL_EARLY_EXIT_EN
    logic unused_b_zero;
    assign unused_b_zero = b_zero;
`endif

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next;
            if (state == LOAD)
                cnt <= '0;
            else if (state == SHIFT)
                cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        next = IDLE;
        case (state)
            IDLE:  next = start ? LOAD : IDLE;
            LOAD:  next = CHECK;
            CHECK: begin
`ifdef MULT_CTRL_EARLY_EXIT_EN
                if (b_zero)
                    next = DONE;
                else
`endif
                if (b_lsb)
                    next = ADD;
                else
                    next = SHIFT;
            end
            ADD:   next = SHIFT;
            SHIFT: next = last_iter ? DONE : CHECK;
            DONE:  next = IDLE;
            default: next = IDLE;  // unused encodings recover to IDLE
        endcase
    end

    // Moore decode: outputs depend on the registered state only
    always_comb begin
        a_enable = 1'b0;
        a_L      = 1'b0;
        b_enable = 1'b0;
        b_L      = 1'b0;
        p_L      = 1'b0;
        Psel     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            LOAD: begin
                a_enable = 1'b1;
                a_L      = 1'b1;
                b_enable = 1'b1;
                b_L      = 1'b1;
                p_L      = 1'b1;
                busy     = 1'b1;
            end
            CHECK: busy = 1'b1;
            ADD: begin
                p_L  = 1'b1;
                Psel = 1'b1;
                busy = 1'b1;
            end
            SHIFT: begin
                a_enable = 1'b1;
                b_enable = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: behavioural datapath plus a job-level latency/product model, directed and random jobs.
module tb_mult_ctrl;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic b_lsb, b_zero;
    logic a_enable, a_L, b_enable, b_L, p_L, Psel, busy, done;

    logic [7:0] a_data = '0, a_reg = '0, p_reg = '0;
    logic [3:0] b_data = '0, b_reg = '0;

    int vectors = 0, misses = 0;
    int exp_cnt = 0, exp_lat = 0;
    logic [7:0] exp_p = '0;
    bit live = 0;

    mult_ctrl #(.B_WIDTH(BW)) dut (
        .Clk(clk), .reset(reset), .start(start), .b_lsb(b_lsb), .b_zero(b_zero),
        .a_enable(a_enable), .a_L(a_L), .b_enable(b_enable), .b_L(b_L),
        .p_L(p_L), .Psel(Psel), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign b_lsb  = b_reg[0];
    assign b_zero = (b_reg == 4'd0);

    // Cycles from the start-sampling edge to the DONE cycle, from the operand b alone
    function automatic int lat(int b);
        int n = 1;
        int bb = b;
        for (int i = 0; i < BW; i++) begin
`ifdef MULT_CTRL_EARLY_EXIT_EN
            if (bb == 0) return n + 2;
`endif
            n += 2 + (bb & 1);
            bb >>= 1;
        end
        return n + 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            misses++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Datapath and job model advance on the same edge as the DUT
    always @(posedge clk) begin
        live <= 1'b1;
        if (a_enable) a_reg <= a_L ? a_data : {a_reg[6:0], 1'b0};
        if (b_enable) b_reg <= b_L ? b_data : {1'b0, b_reg[3:1]};
        if (p_L)      p_reg <= Psel ? 8'(p_reg + a_reg) : 8'd0;
        if (!reset) exp_cnt <= 0;
        else if (exp_cnt == 0) begin
            if (start) begin
                exp_cnt <= 1;
                exp_lat <= lat(int'(b_data));
                exp_p   <= 8'((int'(a_data) * int'(b_data)) % 256);
            end
        end else if (exp_cnt == exp_lat) exp_cnt <= 0;
        else exp_cnt <= exp_cnt + 1;
    end

    always @(negedge clk) begin
        if (live) begin
            chk("busy", int'(busy), int'(exp_cnt != 0));
            chk("done", int'(done), int'(exp_cnt != 0 && exp_cnt == exp_lat));
            if (exp_cnt == 0)
                chk("idle_strobes", int'({a_enable, a_L, b_enable, b_L, p_L, Psel}), 0);
            if (exp_cnt == 1)
                chk("load_strobes", int'({a_enable, a_L, b_enable, b_L, p_L, Psel}), 6'b111110);
            if (exp_cnt != 0 && exp_cnt == exp_lat)
                chk("product", int'(p_reg), int'(exp_p));
        end
    end

    // One directed job; returns the DONE cycle index (LOAD = 1) and P seen in DONE.
    // extra: pulse start mid-job and in the DONE cycle. rst_at: drop reset in that cycle.
    task automatic run_job(input logic [7:0] a, input logic [3:0] b, input bit extra,
                           input int rst_at, output int p, output int n);
        int guard = 0;
        @(negedge clk); #1;
        while (exp_cnt != 0 && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        a_data = a;
        b_data = b;
        start  = 1'b1;
        n = 0;
        p = -1;
        while (1) begin
            @(negedge clk); #1;
            n++;
            start = (extra && n == 5);
            if (n == rst_at) begin
                chk("add_strobes", int'({p_L, Psel}), 2'b11);
                reset = 1'b0;
                @(negedge clk); #1;
                chk("reset_outputs", int'({a_enable, a_L, b_enable, b_L, p_L, Psel, busy, done}), 0);
                reset = 1'b1;
                n = -1;
                return;
            end
            if (done) begin
                p = int'(p_reg);
                if (extra) begin
                    start = 1'b1;
                    @(negedge clk); #1;
                    start = 1'b0;
                    chk("restart_in_done_busy", int'(busy), 0);
                    @(negedge clk); #1;
                    chk("restart_ignored_busy", int'(busy), 0);
                end
                return;
            end
            if (n >= 100) begin
                chk("done_timeout", 0, 1);
                return;
            end
        end
    endtask

    initial begin
        int p, n, ee;
`ifdef MULT_CTRL_EARLY_EXIT_EN
        ee = 1;
`else
        ee = 0;
`endif
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
            chk("reset_idle", int'({a_enable, a_L, b_enable, b_L, p_L, Psel, busy, done}), 0);
        end

        chk("lat_model_b11", lat(11), 13);
        chk("lat_model_b5", lat(5), ee ? 11 : 12);
        chk("lat_model_b0", lat(0), ee ? 3 : 10);

        run_job(8'd13, 4'd11, 0, 0, p, n);
        chk("p_13x11", p, 143);
        chk("lat_13x11", n, 13);
        @(negedge clk); #1;
        chk("busy_after_13x11", int'(busy), 0);

        run_job(8'd7, 4'd5, 0, 0, p, n);
        chk("p_7x5", p, 35);
        chk("lat_7x5", n, ee ? 11 : 12);

        run_job(8'd200, 4'd0, 0, 0, p, n);
        chk("p_200x0", p, 0);
        chk("lat_200x0", n, ee ? 3 : 10);

        run_job(8'd255, 4'd15, 1, 0, p, n);
        chk("p_255x15", p, 241);
        chk("lat_255x15", n, 14);

        run_job(8'd9, 4'd3, 0, 3, p, n);
        chk("reset_mid_add", n, -1);
        run_job(8'd9, 4'd3, 0, 0, p, n);
        chk("p_9x3", p, 27);
        chk("lat_9x3", n, ee ? 9 : 12);

        // Random traffic: operands change only while the model is idle
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk); #1;
            if (exp_cnt == 0) begin
                a_data = 8'($urandom);
                b_data = 4'($urandom);
            end
            start = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 99) != 0);
        end
        @(negedge clk); #1;
        start = 1'b0;
        reset = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        chk("drained_idle", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
